// File: rtl/mem_stage_memwb_pkg.sv
// Shared types and constants for the MEM stage and MEM/WB register.
package mem_stage_memwb_pkg;

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] WAIT_ACK = 1'b1;

    localparam logic [31:0] TIMEOUT_POISON = 32'hDEADBEEF;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic dbl;
        logic addi;
    } wb_ctrl_t;

    localparam wb_ctrl_t CTRL_BUBBLE = '0;

    typedef struct packed {
        logic [31:0] read_data;
        logic [31:0] alu_result;
        logic [31:0] alu2;
        logic [4:0]  write_reg;
        logic [31:0] instr;
    } wb_data_t;

endpackage

// File: rtl/mem_stage_memwb_pipe_reg.sv
// MEM/WB capture register: loads every cycle; a bubble clears the controls
// and leaves the data fields untouched.
module memwb_pipe_reg
    import mem_stage_memwb_pkg::*;
(
    input  logic     Clk,
    input  logic     Reset,
    input  logic     bubble_i,
    input  wb_ctrl_t ctrl_i,
    input  wb_data_t data_i,
    output wb_ctrl_t ctrl_o,
    output wb_data_t data_o
);

    wb_ctrl_t ctrl_q;
    wb_data_t data_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ctrl_q <= '0;
            data_q <= '0;
        end else if (bubble_i) begin
            ctrl_q <= CTRL_BUBBLE;
        end else begin
            ctrl_q <= ctrl_i;
            data_q <= data_i;
        end
    end

    assign ctrl_o = ctrl_q;
    assign data_o = data_q;

endmodule

// File: rtl/mem_stage_memwb.sv
// MEM stage with load handshake, upstream stall and MEM/WB register.
// Optional load timeout enabled by defining MEMWB_TIMEOUT_EN.
module mem_stage_memwb
    import mem_stage_memwb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned STALL_CNT_W    = 32
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   EXMEM_MemRead,
    input  logic                   EXMEM_MemtoReg,
    input  logic                   EXMEM_RegWrite,
    input  logic                   EXMEM_Double,
    input  logic                   EXMEM_addi,
    input  logic [31:0]            EXMEM_ALUResult,
    input  logic [31:0]            EXMEM_ALU2,
    input  logic [4:0]             EXMEM_WriteReg,
    input  logic [31:0]            EXMEM_Instr,
    output logic                   DMem_Req,
    output logic [31:0]            DMem_Addr,
    input  logic [31:0]            DMem_RData,
    input  logic                   DMem_Ack,
    output logic                   MemStall,
    output logic                   MEMWB_RegWrite,
    output logic                   MEMWB_MemtoReg,
    output logic                   MEMWB_Double,
    output logic                   MEMWB_addi,
    output logic [31:0]            MEMWB_ReadData,
    output logic [31:0]            MEMWB_ALUResult,
    output logic [31:0]            MEMWB_ALU2,
    output logic [4:0]             MEMWB_WriteReg,
    output logic [31:0]            MEMWB_Instr,
    output logic [STALL_CNT_W-1:0] StallCount,
    output logic                   MEMWB_Timeout
);

    logic [0:0]             state_q, state_d;
    logic                   bubble;
    logic                   tmo_expired;
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    wb_ctrl_t               ctrl_in, ctrl_out;
    wb_data_t               data_in, data_out;

    assign DMem_Req  = (state_q == IDLE && EXMEM_MemRead) || (state_q == WAIT_ACK);
    assign DMem_Addr = EXMEM_ALUResult;
    assign MemStall  = DMem_Req && !DMem_Ack;

    always_comb begin
        state_d = state_q;
        bubble  = 1'b0;
        ctrl_in = '{reg_write:  EXMEM_RegWrite,
                    mem_to_reg: EXMEM_MemtoReg,
                    dbl:        EXMEM_Double,
                    addi:       EXMEM_addi};
        data_in = '{read_data:  32'h0,
                    alu_result: EXMEM_ALUResult,
                    alu2:       EXMEM_ALU2,
                    write_reg:  EXMEM_WriteReg,
                    instr:      EXMEM_Instr};
        case (state_q)
            IDLE: begin
                if (EXMEM_MemRead) begin
                    if (DMem_Ack) begin
                        data_in.read_data = DMem_RData;
                    end else begin
                        bubble  = 1'b1;
                        state_d = WAIT_ACK;
                    end
                end
            end
            default: begin
                if (DMem_Ack) begin
                    data_in.read_data = DMem_RData;
                    state_d           = IDLE;
                end else if (tmo_expired) begin
                    // Abandon the load: deliver poison that is never written back.
                    data_in.read_data = TIMEOUT_POISON;
                    ctrl_in.reg_write = 1'b0;
                    state_d           = IDLE;
                end else begin
                    bubble = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (MemStall && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
            end
        end
    end

`ifdef MEMWB_TIMEOUT_EN
    logic [31:0] tmo_cnt_q;
    logic        tmo_flag_q;

    assign tmo_expired = (tmo_cnt_q == TIMEOUT_CYCLES - 1);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tmo_cnt_q  <= '0;
            tmo_flag_q <= 1'b0;
        end else begin
            if (state_q == IDLE) begin
                tmo_cnt_q <= '0;
            end else if (!DMem_Ack) begin
                tmo_cnt_q <= tmo_cnt_q + 32'd1;
            end
            if (state_q == WAIT_ACK && !DMem_Ack && tmo_expired) begin
                tmo_flag_q <= 1'b1;
            end
        end
    end

    assign MEMWB_Timeout = tmo_flag_q;
`else
    logic unused_tmo_cfg;

    assign unused_tmo_cfg = ^{TIMEOUT_CYCLES, TIMEOUT_POISON};
    assign tmo_expired    = 1'b0;
    assign MEMWB_Timeout  = 1'b0;
`endif

    memwb_pipe_reg u_pipe_reg (
        .Clk      (Clk),
        .Reset    (Reset),
        .bubble_i (bubble),
        .ctrl_i   (ctrl_in),
        .data_i   (data_in),
        .ctrl_o   (ctrl_out),
        .data_o   (data_out)
    );

    assign MEMWB_RegWrite  = ctrl_out.reg_write;
    assign MEMWB_MemtoReg  = ctrl_out.mem_to_reg;
    assign MEMWB_Double    = ctrl_out.dbl;
    assign MEMWB_addi      = ctrl_out.addi;
    assign MEMWB_ReadData  = data_out.read_data;
    assign MEMWB_ALUResult = data_out.alu_result;
    assign MEMWB_ALU2      = data_out.alu2;
    assign MEMWB_WriteReg  = data_out.write_reg;
    assign MEMWB_Instr     = data_out.instr;
    assign StallCount      = stall_cnt_q;

endmodule
